list_prefetch_buffer: RTL and testbench

- Parametrised, buffered list-stream stage that sits between a list producer (enumerator, cons/concat chain) and a consumer.
- It fetches elements ahead of demand into a DEPTH-entry FIFO, so consumer requests are answered in one cycle whenever data is buffered.
- It generalises the fixed 8-bit, unbuffered list stages to DATA_WIDTH-bit elements.
- The end-of-list marker is retained, so every request after end-of-list returns a valid=0 response.

---
 rtl/list_prefetch_buffer_if.sv | 36 +++
 rtl/list_prefetch_buffer.sv | 143 ++++++++++++++
 tb/tb_list_prefetch_buffer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/list_prefetch_buffer_if.sv
// list_prefetch_buffer_if
//   Bundles the upstream fetch handshake, the downstream request/response
//   handshake and the status outputs of list_prefetch_buffer.
//   slave  : the buffer itself (drives up_req, ack, value, value_valid,
//            level, eol_seen; samples up_ack, up_value, up_value_valid, req)
//   master : the environment around it (producer + consumer side)
interface list_prefetch_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    // upstream list
    logic                  up_req;
    logic                  up_ack;
    logic [DATA_WIDTH-1:0] up_value;
    logic                  up_value_valid;
    // downstream consumer
    logic                  req;
    logic                  ack;
    logic [DATA_WIDTH-1:0] value;
    logic                  value_valid;
    // status
    logic [LVL_W-1:0]      level;
    logic                  eol_seen;

    modport slave (
        output up_req, ack, value, value_valid, level, eol_seen,
        input  up_ack, up_value, up_value_valid, req
    );

    modport master (
        input  up_req, ack, value, value_valid, level, eol_seen,
        output up_ack, up_value, up_value_valid, req
    );
endinterface

// File: rtl/list_prefetch_buffer.sv
// list_prefetch_buffer
//   Buffered list-stream stage. A small fetch FSM pulls elements from the
//   upstream list into a DEPTH-entry FIFO ahead of demand; downstream
//   requests (rising edges of req) are answered from the FIFO head. The
//   end-of-list entry is never popped, so every request after the end
//   returns value_valid=0.
// Ports:
//   clock - single clock, all logic on posedge
//   reset - synchronous, active-high; clears all state
//   bus   - list_prefetch_buffer_if.slave (upstream handshake, downstream
//           handshake, level, eol_seen)
module list_prefetch_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    list_prefetch_buffer_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, GAP} fetch_state_e;
    typedef logic [DATA_WIDTH:0] entry_t;   // {valid, value}

    fetch_state_e          state_q, state_d;
    logic                  up_req_q, up_req_d;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  eol_seen_q, eol_seen_d;
    logic                  last_req_q, last_req_d;
    logic                  pending_q, pending_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  value_valid_q, value_valid_d;

    logic   rise, push, pop, do_resp;
    entry_t head;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        head    = mem_q[rd_ptr_q];
        rise    = bus.req & ~last_req_q;
        push    = (state_q == WAIT) & bus.up_ack;
        // A fresh edge is served straight away when data is buffered; a
        // request arriving on an empty FIFO waits in pending.
        do_resp = (pending_q | rise) & (level_q != '0);
        // The end-of-list entry stays at the head forever.
        pop     = do_resp & head[DATA_WIDTH];

        state_d  = state_q;
        up_req_d = up_req_q;
        case (state_q)
            IDLE: begin
                // Checking capacity only at issue is enough: while waiting
                // the level can only go down.
                if (!eol_seen_q && (level_q < LVL_W'(DEPTH))) begin
                    up_req_d = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.up_ack) begin
                    up_req_d = 1'b0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                up_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        eol_seen_d = eol_seen_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.up_value_valid, bus.up_value};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            if (!bus.up_value_valid) begin
                eol_seen_d = 1'b1;
            end
        end
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        last_req_d    = bus.req;
        // One flag, not a count: extra edges while pending are absorbed.
        pending_d     = do_resp ? 1'b0 : (pending_q | rise);
        ack_d         = do_resp;
        value_d       = do_resp ? head[DATA_WIDTH-1:0] : value_q;
        value_valid_d = do_resp ? head[DATA_WIDTH]     : value_valid_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            up_req_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            level_q       <= '0;
            eol_seen_q    <= 1'b0;
            last_req_q    <= 1'b0;
            pending_q     <= 1'b0;
            ack_q         <= 1'b0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            up_req_q      <= up_req_d;
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            level_q       <= level_d;
            eol_seen_q    <= eol_seen_d;
            last_req_q    <= last_req_d;
            pending_q     <= pending_d;
            ack_q         <= ack_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
        end
    end

    assign bus.up_req      = up_req_q;
    assign bus.ack         = ack_q;
    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.level       = level_q;
    assign bus.eol_seen    = eol_seen_q;
endmodule

// File: tb/tb_list_prefetch_buffer.sv
// Testbench for list_prefetch_buffer: one DATA_WIDTH=8/DEPTH=4 instance and
// one DATA_WIDTH=16/DEPTH=1 instance sharing clock and reset. Upstream
// producers are behavioural; expected responses come from the stream of
// elements the producer handed over and from handshake counts.
module tb_list_prefetch_buffer;
    localparam int W0 = 8, D0 = 4, W1 = 16, D1 = 1;
    localparam int LW0 = $clog2(D0 + 1);
    localparam int LW1 = $clog2(D1 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    list_prefetch_buffer_if #(.DATA_WIDTH(W0), .DEPTH(D0)) b0 ();
    list_prefetch_buffer_if #(.DATA_WIDTH(W1), .DEPTH(D1)) b1 ();

    list_prefetch_buffer #(.DATA_WIDTH(W0), .DEPTH(D0)) u0 (
        .clock(clk), .reset(rst), .bus(b0.slave));
    list_prefetch_buffer #(.DATA_WIDTH(W1), .DEPTH(D1)) u1 (
        .clock(clk), .reset(rst), .bus(b1.slave));

    int n_run = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- upstream producer for instance 0 ----------------
    bit          auto0 = 1'b1;   // producer drives up_ack by itself
    bit          inf0 = 1'b0;    // endless counter 0,1,2,... instead of list0
    bit          rnd_dly0 = 1'b0;
    int          dly0 = 0;       // cycles up_req is seen before acking
    logic [W0:0] list0 [$];
    logic [W0:0] sent0 [$];      // elements handed over since last reset
    int          idx0 = 0, wait0 = 0, ack_cyc0 = -1;

    initial begin
        logic [W0:0] e;
        b0.up_ack = 1'b0; b0.up_value = '0; b0.up_value_valid = 1'b0; b0.req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin idx0 = 0; wait0 = 0; sent0.delete(); end
            if (!auto0) continue;
            b0.up_ack = 1'b0;
            if (!rst && b0.up_req) begin
                if (wait0 >= dly0) begin
                    e = inf0 ? {1'b1, W0'(idx0)} : list0[idx0];
                    {b0.up_value_valid, b0.up_value} = e;
                    b0.up_ack = 1'b1;
                    sent0.push_back(e);
                    idx0++; wait0 = 0; ack_cyc0 = cyc;
                    if (rnd_dly0) dly0 = $urandom_range(0, 3);
                end else begin
                    wait0++;
                end
            end
        end
    end

    // ---------------- upstream producer for instance 1 ----------------
    logic [W1:0] list1 [$];
    int          idx1 = 0;
    initial begin
        b1.up_ack = 1'b0; b1.up_value = '0; b1.up_value_valid = 1'b0; b1.req = 1'b0;
        forever begin
            @(negedge clk);
            b1.up_ack = 1'b0;
            if (rst) idx1 = 0;
            else if (b1.up_req) begin
                {b1.up_value_valid, b1.up_value} = list1[idx1];
                b1.up_ack = 1'b1;
                idx1++;
            end
        end
    end

    // ---------------- monitors (handshake arithmetic) ----------------
    // Expected level = upstream handshakes - valid responses.
    int npush0 = 0, npop0 = 0, lvl_bad0 = 0, nrise0 = 0, ack_long0 = 0, bad1 = 0;
    logic upr_prev0 = 1'b0, ack_prev0 = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            npush0 <= 0; npop0 <= 0; upr_prev0 <= 1'b0; ack_prev0 <= 1'b0;
        end else begin
            if (b0.up_req && b0.up_ack) npush0 <= npush0 + 1;
            if (b0.ack && b0.value_valid) npop0 <= npop0 + 1;
            if (b0.level !== LW0'(npush0 - npop0 - int'(b0.ack && b0.value_valid)) || b0.level > LW0'(D0))
                lvl_bad0 <= lvl_bad0 + 1;
            if (b0.up_req && !upr_prev0) nrise0 <= nrise0 + 1;
            if (b0.ack && ack_prev0) ack_long0 <= ack_long0 + 1;
            upr_prev0 <= b0.up_req;
            ack_prev0 <= b0.ack;
            if (b1.up_req && b1.level == LW1'(1)) bad1 <= bad1 + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- request helpers ----------------
    task automatic ask0(input int hold, output logic [W0-1:0] v, output logic vv,
                        output int rcyc, output int acyc);
        bit got = 1'b0;
        @(negedge clk);
        b0.req = 1'b1; rcyc = cyc; acyc = -1; v = '0; vv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == hold) b0.req = 1'b0;   // dropping early must not cancel
            if (b0.ack) begin got = 1'b1; v = b0.value; vv = b0.value_valid; acyc = cyc; break; end
        end
        b0.req = 1'b0;
        if (!got) begin n_run++; n_fail++; $display("FAIL ask0 timeout: got no ack expected ack"); end
    endtask

    task automatic ask1(output logic [W1-1:0] v, output logic vv);
        bit got = 1'b0;
        @(negedge clk);
        b1.req = 1'b1; v = '0; vv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b1.ack) begin got = 1'b1; v = b1.value; vv = b1.value_valid; break; end
        end
        b1.req = 1'b0;
        if (!got) begin n_run++; n_fail++; $display("FAIL ask1 timeout: got no ack expected ack"); end
    endtask

    task automatic wait_lvl0(input int lvl, input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b0.level == LW0'(lvl)) break;
        end
        check(nm, b0.level, lvl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; b0.req = 1'b0; b1.req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int         hold;
        logic [7:0] val;
        logic       vld;
        int         lvl;
    } vec_t;

    initial begin
        vec_t        tab [5];
        logic [W0-1:0] v;
        logic          vv;
        logic [W1-1:0] v1;
        logic          vv1;
        logic [W0:0]   e;
        int rc, ac, r0, nacks, saw, t_rel;

        tab[0] = '{0, 8'd1, 1'b1, 3};
        tab[1] = '{5, 8'd2, 1'b1, 2};
        tab[2] = '{0, 8'd3, 1'b1, 1};
        tab[3] = '{1, 8'd3, 1'b0, 1};
        tab[4] = '{9, 8'd3, 1'b0, 1};

        list0 = '{9'h101, 9'h102, 9'h103, 9'h003};
        list1 = '{17'h18001, 17'h1FFFF, 17'h0FFFF};

        // ---- reset values ----
        repeat (2) @(negedge clk);
        check("rst up_req", b0.up_req, 0);
        check("rst ack", b0.ack, 0);
        check("rst value", b0.value, 0);
        check("rst value_valid", b0.value_valid, 0);
        check("rst level", b0.level, 0);
        check("rst eol_seen", b0.eol_seen, 0);
        rst = 1'b0;

        // ---- finite list 1,2,3,end: fill then table of requests ----
        wait_lvl0(4, "fill level");
        check("fill eol_seen", b0.eol_seen, 1);
        saw = 0;
        repeat (6) begin @(negedge clk); if (b0.up_req) saw = 1; end
        check("no fetch after eol", saw, 0);
        for (int i = 0; i < 5; i++) begin
            ask0(tab[i].hold, v, vv, rc, ac);
            check($sformatf("tab%0d value", i), v, tab[i].val);
            check($sformatf("tab%0d valid", i), vv, tab[i].vld);
            check($sformatf("tab%0d latency", i), ac - rc, 1);
            check($sformatf("tab%0d level", i), b0.level, tab[i].lvl);
            @(negedge clk);
            check($sformatf("tab%0d ack pulse", i), b0.ack, 0);
        end

        // ---- endless counter, no demand: settle full, one request ----
        inf0 = 1'b1; dly0 = 0;
        do_reset();
        wait_lvl0(4, "counter fill level");
        saw = 0;
        repeat (6) begin @(negedge clk); if (b0.up_req) saw = 1; end
        check("full no fetch", saw, 0);
        r0 = nrise0;
        ask0(2, v, vv, rc, ac);
        check("counter first value", {vv, v}, 9'h100);
        repeat (12) @(negedge clk);
        check("one refill fetch", nrise0 - r0, 1);
        check("refill level", b0.level, 4);

        // ---- slow upstream, request on empty FIFO ----
        dly0 = 10;
        do_reset();
        t_rel = cyc;
        @(negedge clk);
        ask0(100, v, vv, rc, ac);
        check("empty ack after push", ac, ack_cyc0 + 2);
        check("empty fetch after release", (ack_cyc0 > t_rel) ? 1 : 0, 1);
        check("empty value", {vv, v}, 9'h100);

        // ---- two rising edges on an empty FIFO give one response ----
        dly0 = 6;
        do_reset();
        nacks = 0; e = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b0.ack) begin nacks++; e = {b0.value_valid, b0.value}; end
            if (i == 0 || i == 2) b0.req = 1'b1;
            if (i == 1 || i == 3) b0.req = 1'b0;
        end
        check("pending is a flag", nacks, 1);
        check("pending value", e, 9'h100);

        // ---- random demand against random upstream latency ----
        dly0 = 0; rnd_dly0 = 1'b1;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            ask0($urandom_range(0, 6), v, vv, rc, ac);
            if (sent0.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL rand%0d: got 0x%0h expected no response", k, {vv, v});
            end else begin
                e = sent0.pop_front();
                check($sformatf("rand%0d element", k), {vv, v}, e);
            end
        end
        rnd_dly0 = 1'b0; dly0 = 0;
        check("level tracks handshakes", lvl_bad0, 0);
        check("ack single cycle", ack_long0, 0);

        // ---- reset while waiting on upstream with level 3 ----
        do_reset();
        wait_lvl0(3, "pre-reset level");
        dly0 = 40;
        for (int i = 0; i < 20 && !b0.up_req; i++) @(negedge clk);
        check("in WAIT before reset", b0.up_req, 1);
        @(negedge clk);
        auto0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        b0.up_ack = 1'b1; b0.up_value = 8'hAA; b0.up_value_valid = 1'b1;
        idx0 = 0; wait0 = 0; sent0.delete();
        @(negedge clk);
        check("mid rst up_req", b0.up_req, 0);
        check("mid rst ack", b0.ack, 0);
        check("mid rst value", b0.value, 0);
        check("mid rst value_valid", b0.value_valid, 0);
        check("mid rst level", b0.level, 0);
        check("mid rst eol_seen", b0.eol_seen, 0);
        rst = 1'b0; b0.up_ack = 1'b0; dly0 = 0; auto0 = 1'b1;
        @(negedge clk);
        check("fetch restarts", b0.up_req, 1);
        ask0(3, v, vv, rc, ac);
        check("no stale push", {vv, v}, 9'h100);

        // ---- 16-bit, single-entry instance ----
        do_reset();
        for (int i = 0; i < 50 && b1.level != LW1'(1); i++) @(negedge clk);
        check("w16 level", b1.level, 1);
        ask1(v1, vv1); check("w16 first", {vv1, v1}, 17'h18001);
        ask1(v1, vv1); check("w16 second", {vv1, v1}, 17'h1FFFF);
        ask1(v1, vv1); check("w16 end", {vv1, v1}, 17'h0FFFF);
        ask1(v1, vv1); check("w16 end again", {vv1, v1}, 17'h0FFFF);
        repeat (5) @(negedge clk);
        check("w16 eol_seen", b1.eol_seen, 1);
        check("w16 no up_req when full", bad1, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
